// File: rtl/r_channel_order_router.sv
// In-order R-channel return router: records {slave, master} per AR handshake and
// steers each slave's read bursts back to the issuing master in acceptance order.
module r_channel_order_router #(
  parameter int unsigned Masters_Num   = 2,
  parameter int unsigned Num_Of_Slaves = 4,
  parameter int unsigned Data_width    = 32,
  parameter int unsigned Order_Depth   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           AR_Hs_Done,
  input  logic [$clog2(Num_Of_Slaves)-1:0] AR_Hs_Slave,
  input  logic [$clog2(Masters_Num)-1:0] AR_Hs_Master,
  output logic                           AR_Stall,
  output logic [$clog2(Order_Depth):0]   Outstanding,
  output logic                           Overflow_Err,
  input  logic [Data_width-1:0]          M00_AXI_rdata,
  input  logic [1:0]                     M00_AXI_rresp,
  input  logic                           M00_AXI_rlast,
  input  logic                           M00_AXI_rvalid,
  output logic                           M00_AXI_rready,
  input  logic [Data_width-1:0]          M01_AXI_rdata,
  input  logic [1:0]                     M01_AXI_rresp,
  input  logic                           M01_AXI_rlast,
  input  logic                           M01_AXI_rvalid,
  output logic                           M01_AXI_rready,
  input  logic [Data_width-1:0]          M02_AXI_rdata,
  input  logic [1:0]                     M02_AXI_rresp,
  input  logic                           M02_AXI_rlast,
  input  logic                           M02_AXI_rvalid,
  output logic                           M02_AXI_rready,
  input  logic [Data_width-1:0]          M03_AXI_rdata,
  input  logic [1:0]                     M03_AXI_rresp,
  input  logic                           M03_AXI_rlast,
  input  logic                           M03_AXI_rvalid,
  output logic                           M03_AXI_rready,
  output logic [Data_width-1:0]          S00_AXI_rdata,
  output logic [1:0]                     S00_AXI_rresp,
  output logic                           S00_AXI_rlast,
  output logic                           S00_AXI_rvalid,
  input  logic                           S00_AXI_rready,
  output logic [Data_width-1:0]          S01_AXI_rdata,
  output logic [1:0]                     S01_AXI_rresp,
  output logic                           S01_AXI_rlast,
  output logic                           S01_AXI_rvalid,
  input  logic                           S01_AXI_rready
);

  localparam int unsigned MID_W = $clog2(Masters_Num);
  localparam int unsigned SID_W = $clog2(Num_Of_Slaves);
  localparam int unsigned PTR_W = $clog2(Order_Depth);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = SID_W + MID_W;
  localparam int unsigned N_M   = 4;
  localparam int unsigned N_S   = 2;

  // Slave-side (Mxx) and master-side (Syy) channels gathered into arrays
  logic [Data_width-1:0] m_rdata  [N_M];
  logic [1:0]            m_rresp  [N_M];
  logic                  m_rlast  [N_M];
  logic                  m_rvalid [N_M];
  logic                  m_rready [N_M];
  logic [Data_width-1:0] s_rdata  [N_S];
  logic [1:0]            s_rresp  [N_S];
  logic                  s_rlast  [N_S];
  logic                  s_rvalid [N_S];
  logic                  s_rready [N_S];

  assign m_rdata  = '{M00_AXI_rdata, M01_AXI_rdata, M02_AXI_rdata, M03_AXI_rdata};
  assign m_rresp  = '{M00_AXI_rresp, M01_AXI_rresp, M02_AXI_rresp, M03_AXI_rresp};
  assign m_rlast  = '{M00_AXI_rlast, M01_AXI_rlast, M02_AXI_rlast, M03_AXI_rlast};
  assign m_rvalid = '{M00_AXI_rvalid, M01_AXI_rvalid, M02_AXI_rvalid, M03_AXI_rvalid};
  assign s_rready = '{S00_AXI_rready, S01_AXI_rready};

  assign M00_AXI_rready = m_rready[0];
  assign M01_AXI_rready = m_rready[1];
  assign M02_AXI_rready = m_rready[2];
  assign M03_AXI_rready = m_rready[3];
  assign S00_AXI_rdata  = s_rdata[0];
  assign S00_AXI_rresp  = s_rresp[0];
  assign S00_AXI_rlast  = s_rlast[0];
  assign S00_AXI_rvalid = s_rvalid[0];
  assign S01_AXI_rdata  = s_rdata[1];
  assign S01_AXI_rresp  = s_rresp[1];
  assign S01_AXI_rlast  = s_rlast[1];
  assign S01_AXI_rvalid = s_rvalid[1];

  logic [ENT_W-1:0] fifo_q [Order_Depth];
  logic [ENT_W-1:0] fifo_d [Order_Depth];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ENT_W-1:0] head;
  logic [SID_W-1:0] head_sid;
  logic [MID_W-1:0] head_mid;
  logic             nonempty, full, pop, push, drop;

  assign head     = fifo_q[rd_ptr_q];
  assign head_sid = head[ENT_W-1:MID_W];
  assign head_mid = head[MID_W-1:0];
  assign nonempty = (count_q != '0);
  assign full     = (count_q == CNT_W'(Order_Depth));
  assign pop      = nonempty && m_rvalid[head_sid] && s_rready[head_mid] && m_rlast[head_sid];
  assign push     = AR_Hs_Done && (!full || pop);
  assign drop     = AR_Hs_Done && full && !pop;

  assign AR_Stall     = full;
  assign Outstanding  = count_q;
  assign Overflow_Err = ovf_q;

  // Pure pass-through from the head slave to the head master; everything else idle
  always_comb begin
    for (int j = 0; j < int'(N_S); j++) begin
      s_rdata[j]  = '0;
      s_rresp[j]  = '0;
      s_rlast[j]  = 1'b0;
      s_rvalid[j] = 1'b0;
    end
    for (int i = 0; i < int'(N_M); i++) begin
      m_rready[i] = 1'b0;
    end
    if (nonempty) begin
      s_rdata[head_mid]  = m_rdata[head_sid];
      s_rresp[head_mid]  = m_rresp[head_sid];
      s_rlast[head_mid]  = m_rlast[head_sid];
      s_rvalid[head_mid] = m_rvalid[head_sid];
      m_rready[head_sid] = s_rready[head_mid];
    end
  end

  // Order FIFO next state; on full push+pop the write slot is the one being vacated
  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      fifo_d[wr_ptr_q] = {AR_Hs_Slave, AR_Hs_Master};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < int'(Order_Depth); k++) begin
        fifo_q[k] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
